// File: rtl/risc16_pkg.sv
// Shared constants and loader state encoding for the risc16 instruction-memory path.
package risc16_pkg;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 16;
  localparam int MAX_WORDS = 64;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;
endpackage

// File: rtl/prog_loader.sv
// Loads a length/words/XOR-checksum byte stream into instruction memory; one write cycle per word.
// byte_ready is low in WRITE/DONE/ERROR and the host holds its byte; cpu_hold releases only in DONE.
module prog_loader #(
  parameter int ADDR_W = risc16_pkg::ADDR_W,
  parameter int DATA_W = risc16_pkg::DATA_W
) (
  input  logic              clk0,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              start,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  import risc16_pkg::*;

  localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   n_q;
  logic [7:0]        csum_q;
  logic [DATA_W-1:0] din_q;
  logic              xfer;
  logic              last_word;
  logic              len_bad;

  assign xfer      = byte_valid && byte_ready;
  assign len_bad   = (byte_data == 8'd0) || (byte_data > MAX_LEN);
  // Compared one bit wider so N=64 terminates without the address ever wrapping.
  assign last_word = (({1'b0, addr_q} + (ADDR_W+1)'(1)) == n_q);
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) state_q <= ST_LEN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LEN:   if (xfer) state_d = len_bad ? ST_ERROR : ST_HI;
      ST_HI:    if (xfer) state_d = ST_LO;
      ST_LO:    if (xfer) state_d = ST_WRITE;
      ST_WRITE: state_d = last_word ? ST_CHECK : ST_HI;
      ST_CHECK: if (xfer) state_d = (byte_data == csum_q) ? ST_DONE : ST_ERROR;
      ST_DONE,
      ST_ERROR: if (start) state_d = ST_LEN;
      default:  state_d = ST_LEN;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    mem_csb    = 1'b1;
    mem_web    = 1'b1;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state_q)
      ST_LEN, ST_HI, ST_LO, ST_CHECK: byte_ready = 1'b1;
      ST_WRITE: begin
        mem_csb = 1'b0;
        mem_web = 1'b0;
      end
      ST_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ST_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      n_q    <= '0;
      csum_q <= '0;
      din_q  <= '0;
    end else begin
      case (state_q)
        ST_LEN: if (xfer && !len_bad) begin
          n_q    <= byte_data[ADDR_W:0];
          addr_q <= '0;
          csum_q <= '0;
        end
        ST_HI: if (xfer) begin
          din_q[DATA_W-1:DATA_W-8] <= byte_data;
          csum_q                   <= csum_q ^ byte_data;
        end
        ST_LO: if (xfer) begin
          din_q[7:0] <= byte_data;
          csum_q     <= csum_q ^ byte_data;
        end
        ST_WRITE: if (!last_word) addr_q <= addr_q + ADDR_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: stream-level model predicts writes and outcome, checked every cycle.
module tb_prog_loader;
  logic        clk0 = 1'b0;
  logic        reset = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        start = 1'b0;
  logic        mem_csb, mem_web;
  logic [5:0]  mem_addr;
  logic [15:0] mem_din;
  logic        cpu_hold, done, error;

  int tests = 0;
  int fails = 0;
  int write_cnt = 0;
  int max_gap = 0;
  logic prev_wr = 1'b0;
  logic [15:0] mem_img [64];
  logic [21:0] exp_q [$];
  logic [7:0]  stream [$];

  prog_loader dut (
    .clk0(clk0), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .start(start), .mem_csb(mem_csb), .mem_web(mem_web),
    .mem_addr(mem_addr), .mem_din(mem_din), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk0 = ~clk0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Predicts the writes and outcome of the stream: 0 = incomplete, 1 = done, 2 = error.
  function automatic int model_load();
    int n;
    logic [7:0] cs;
    if (stream.size() == 0) return 0;
    n = int'(stream[0]);
    if (n == 0 || n > 64) return 2;
    cs = 8'h00;
    for (int w = 0; w < n; w++) begin
      if (stream.size() < 3 + 2 * w) return 0;
      cs = cs ^ stream[1 + 2 * w] ^ stream[2 + 2 * w];
      exp_q.push_back({6'(w), stream[1 + 2 * w], stream[2 + 2 * w]});
    end
    if (stream.size() <= 1 + 2 * n) return 0;
    return (stream[1 + 2 * n] == cs) ? 1 : 2;
  endfunction

  always @(negedge clk0) begin
    if (!reset) begin
      prev_wr = 1'b0;
    end else begin
      if (!mem_web || !mem_csb) begin
        check("write_strobes", {30'd0, mem_csb, mem_web}, 32'd0);
        check("write_one_cycle", prev_wr, 1'b0);
        check("write_no_ready", byte_ready, 1'b0);
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [21:0] e;
          e = exp_q.pop_front();
          check("write_addr", mem_addr, e[21:16]);
          check("write_data", mem_din, e[15:0]);
        end
        mem_img[mem_addr] = mem_din;
        write_cnt++;
      end
      prev_wr = !mem_web;
      check("hold_vs_done", cpu_hold, !done);
      check("done_error_excl", done & error, 1'b0);
      if (done || error) check("ready_in_terminal", byte_ready, 1'b0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int g;
    int waited;
    g = $urandom_range(max_gap, 0);
    byte_valid = 1'b0;
    repeat (g) begin @(posedge clk0); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    waited = 0;
    forever begin
      @(negedge clk0);
      if (byte_ready) break;
      waited++;
      if (waited > 64) begin
        check("byte_accepted", byte_ready, 1'b1);
        break;
      end
    end
    @(posedge clk0); #1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic run_stream(input string name);
    int outcome;
    outcome = model_load();
    foreach (stream[i]) send_byte(stream[i]);
    @(negedge clk0);
    check({name, "_done"},  done,  outcome == 1);
    check({name, "_error"}, error, outcome == 2);
    check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rearm(input string name);
    start = 1'b1;
    @(posedge clk0); #1;
    start = 1'b0;
    check({name, "_ready"}, byte_ready, 1'b1);
    check({name, "_state"}, {done, error}, 2'b00);
  endtask

  initial begin
    int wc0;
    logic [7:0] x;
    #12;
    check("rst_ready", byte_ready, 1'b1);
    check("rst_strobes", {mem_csb, mem_web}, 2'b11);
    check("rst_hold", cpu_hold, 1'b1);
    check("rst_flags", {done, error}, 2'b00);
    check("rst_addr", mem_addr, 6'd0);
    check("rst_din", mem_din, 16'h0000);
    @(posedge clk0); #1;
    reset = 1'b1;

    // Two-word load with correct checksum.
    stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_stream("two_word");
    check("two_word_img0", mem_img[0], 16'h1234);
    check("two_word_img1", mem_img[1], 16'hABCD);
    check("two_word_cpu_hold", cpu_hold, 1'b0);
    rearm("rearm_a");

    // Illegal length bytes.
    wc0 = write_cnt;
    stream = '{8'h00};
    run_stream("len_zero");
    check("len_zero_ready", byte_ready, 1'b0);
    rearm("rearm_b");
    stream = '{8'h41};
    run_stream("len_41");
    check("len_41_ready", byte_ready, 1'b0);
    check("len_err_no_writes", write_cnt - wc0, 0);
    rearm("rearm_c");

    // Bad checksum: word is still written, core stays held.
    stream = '{8'h01, 8'hFF, 8'h00, 8'h00};
    run_stream("bad_csum");
    check("bad_csum_img0", mem_img[0], 16'hFF00);
    check("bad_csum_hold", cpu_hold, 1'b1);
    rearm("rearm_d");

    // Full 64-word load with random data and random valid gaps.
    wc0 = write_cnt;
    max_gap = 3;
    stream = '{8'h40};
    x = 8'h00;
    for (int i = 0; i < 128; i++) begin
      logic [7:0] r;
      r = 8'($urandom_range(255, 0));
      x = x ^ r;
      stream.push_back(r);
    end
    stream.push_back(x);
    run_stream("full64");
    check("full64_count", write_cnt - wc0, 64);
    check("full64_last", mem_img[63], {stream[127], stream[128]});
    rearm("rearm_e");

    // Reset after the high byte of word 5.
    wc0 = write_cnt;
    max_gap = 1;
    stream = '{8'h08};
    for (int i = 0; i < 11; i++) stream.push_back(8'(8'h10 + i));
    void'(model_load());
    foreach (stream[i]) send_byte(stream[i]);
    #2 reset = 1'b0;
    #1;
    check("midrst_ready", byte_ready, 1'b1);
    check("midrst_strobes", {mem_csb, mem_web}, 2'b11);
    check("midrst_hold", cpu_hold, 1'b1);
    check("midrst_flags", {done, error}, 2'b00);
    check("midrst_addr", mem_addr, 6'd0);
    check("midrst_din", mem_din, 16'h0000);
    @(posedge clk0); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk0);
    @(negedge clk0);
    check("midrst_writes", write_cnt - wc0, 5);
    check("midrst_writes_left", 32'(exp_q.size()), 32'd0);
    stream = '{8'h01, 8'h00, 8'h07, 8'h07};
    run_stream("fresh");
    check("fresh_img0", mem_img[0], 16'h0007);

    // start held high from DONE through a complete load.
    @(posedge clk0); #1;
    start = 1'b1;
    stream = '{8'h01, 8'h12, 8'h34, 8'h26};
    run_stream("start_held");
    @(posedge clk0); #1;
    check("start_held_leave_done", done, 1'b0);
    check("start_held_ready", byte_ready, 1'b1);
    start = 1'b0;
    check("start_held_img0", mem_img[0], 16'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
